dma_ctrl: RTL and testbench

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dma_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
// 6809 DMA controller: halts the CPU, copies CNT bytes from SRC to DST, then flags DONE/IRQ.
// Two E cycles per byte once HALT is acknowledged; a dropped grant re-requests and repeats the in-flight byte.
module dma_ctrl (
   input  logic        i_eclk,
   input  logic        i_reset,
   input  logic        i_cs_n,
   input  logic        i_rw,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_data,
   input  logic        i_ba,
   input  logic        i_bs,
   output logic        o_halt_n,
   output logic        o_irq_n,
   output logic [15:0] o_addr,
   output logic        o_rw,
   output logic        o_bus_oe,
   output logic [7:0]  o_data,
   output logic        o_data_oe
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RD   = 3'd2,
      S_WR   = 3'd3,
      S_REL  = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] src;
   logic [15:0] dst;
   logic [15:0] cnt;
   logic [15:0] cnt_dec;
   logic        ien;
   logic        done;
   logic [7:0]  latch;
   logic [2:0]  reg_sel;
   logic        grant;
   logic        reg_wr;
   logic        reg_rd;
   logic        status_rd;
   logic        start;
   logic [7:0]  status;
   logic [7:0]  rd_dat;
   logic        unused_addr;

   assign reg_sel     = i_addr[2:0];
   assign unused_addr = ^i_addr[15:3];
   assign grant       = i_ba & i_bs;
   assign reg_wr      = !i_cs_n && !i_rw && (state == S_IDLE);
   // reads are gated by reset so the data drivers stay off while reset is held
   assign reg_rd      = !i_cs_n && i_rw && i_reset;
   assign status_rd   = reg_rd && (reg_sel == 3'd6);
   assign start       = reg_wr && (reg_sel == 3'd6) && i_data[0];
   assign cnt_dec     = cnt - 16'd1;
   assign status      = {(state != S_IDLE), done, 4'b0000, ien, 1'b0};
   assign o_irq_n     = !(done && ien);

   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      o_halt_n  = 1'b1;
      o_bus_oe  = 1'b0;
      o_addr    = 16'h0000;
      o_rw      = 1'b1;
      o_data    = 8'h00;
      o_data_oe = 1'b0;
      if (reg_rd) begin
         o_data    = rd_dat;
         o_data_oe = 1'b1;
      end
      case (state)
         S_IDLE: begin
            if (start && (cnt != 16'h0000)) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            o_halt_n = 1'b0;
            if (grant) begin
               state_nxt = S_RD;
            end
         end
         S_RD: begin
            o_halt_n  = 1'b0;
            o_bus_oe  = 1'b1;
            o_addr    = src;
            o_data    = 8'h00;
            o_data_oe = 1'b0;
            state_nxt = grant ? S_WR : S_REQ;
         end
         S_WR: begin
            o_halt_n  = 1'b0;
            o_bus_oe  = 1'b1;
            o_addr    = dst;
            o_rw      = 1'b0;
            o_data    = latch;
            o_data_oe = 1'b1;
            if (!grant) begin
               state_nxt = S_REQ;
            end else if (cnt_dec != 16'h0000) begin
               state_nxt = S_RD;
            end else begin
               state_nxt = S_REL;
            end
         end
         S_REL: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rd_dat = 8'h00;
      case (reg_sel)
         3'd0:    rd_dat = src[15:8];
         3'd1:    rd_dat = src[7:0];
         3'd2:    rd_dat = dst[15:8];
         3'd3:    rd_dat = dst[7:0];
         3'd4:    rd_dat = cnt[15:8];
         3'd5:    rd_dat = cnt[7:0];
         3'd6:    rd_dat = status;
         default: rd_dat = 8'h00;
      endcase
   end

   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         src   <= 16'h0000;
         dst   <= 16'h0000;
         cnt   <= 16'h0000;
         ien   <= 1'b0;
         done  <= 1'b0;
         latch <= 8'h00;
      end else begin
         if (reg_wr) begin
            case (reg_sel)
               3'd0:    src[15:8] <= i_data;
               3'd1:    src[7:0]  <= i_data;
               3'd2:    dst[15:8] <= i_data;
               3'd3:    dst[7:0]  <= i_data;
               3'd4:    cnt[15:8] <= i_data;
               3'd5:    cnt[7:0]  <= i_data;
               3'd6:    ien       <= i_data[1];
               default: ;
            endcase
         end
         if ((state == S_RD) && grant) begin
            latch <= i_data;
         end
         // pointers only advance once the write has completed under grant
         if ((state == S_WR) && grant) begin
            src <= src + 16'd1;
            dst <= dst + 16'd1;
            cnt <= cnt_dec;
         end
         if (state == S_REL) begin
            done <= 1'b1;
         end else if (start) begin
            done <= (cnt == 16'h0000);
         end else if (status_rd) begin
            done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dma_ctrl.sv
// Randomized bench for dma_ctrl: a memory model answers DMA reads, expected bus traffic is derived from SRC/DST/CNT arithmetic.
module tb_dma_ctrl;

   logic        i_eclk = 1'b0;
   logic        i_reset;
   logic        i_cs_n;
   logic        i_rw;
   logic [15:0] i_addr;
   logic [7:0]  i_data;
   logic        i_ba;
   logic        i_bs;
   logic        o_halt_n;
   logic        o_irq_n;
   logic [15:0] o_addr;
   logic        o_rw;
   logic        o_bus_oe;
   logic [7:0]  o_data;
   logic        o_data_oe;

   int checks   = 0;
   int failures = 0;

   dma_ctrl dut (
      .i_eclk    (i_eclk),
      .i_reset   (i_reset),
      .i_cs_n    (i_cs_n),
      .i_rw      (i_rw),
      .i_addr    (i_addr),
      .i_data    (i_data),
      .i_ba      (i_ba),
      .i_bs      (i_bs),
      .o_halt_n  (o_halt_n),
      .o_irq_n   (o_irq_n),
      .o_addr    (o_addr),
      .o_rw      (o_rw),
      .o_bus_oe  (o_bus_oe),
      .o_data    (o_data),
      .o_data_oe (o_data_oe)
   );

   always #5 i_eclk = ~i_eclk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   task automatic reg_wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge i_eclk);
      i_cs_n = 1'b0;
      i_rw   = 1'b0;
      i_addr = a;
      i_data = d;
      @(negedge i_eclk);
      i_cs_n = 1'b1;
      i_rw   = 1'b1;
   endtask

   task automatic reg_rd(input logic [15:0] a, output logic [7:0] d);
      @(negedge i_eclk);
      i_cs_n = 1'b0;
      i_rw   = 1'b1;
      i_addr = a;
      #1;
      d = o_data;
      chk("rd_oe", o_data_oe, 1);
      @(negedge i_eclk);
      i_cs_n = 1'b1;
   endtask

   task automatic run_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] cnt,
                           input logic [7:0] ctrl, input int gd, input int drop_at,
                           input bit rnd_drop, input bit busy_io);
      logic        ien;
      logic [7:0]  d;
      logic [15:0] es;
      logic [15:0] ed;
      int          k;
      int          first_rd;
      int          drops;
      int          wait_n;
      bit          fin;
      bit          drop_pending;
      bit          drop_done;
      bit          do_drop;
      ien = ctrl[1];
      reg_wr(16'd0, src[15:8]);
      reg_wr(16'd1, src[7:0]);
      reg_wr(16'd2, dst[15:8]);
      reg_wr(16'd3, dst[7:0]);
      reg_wr(16'd4, cnt[15:8]);
      reg_wr(16'd5, cnt[7:0]);
      reg_wr(16'd6, ctrl);
      k = 0; first_rd = -1; drops = 0; wait_n = gd;
      fin = 0; drop_pending = 0; drop_done = 0;
      if (cnt == 16'h0000) begin
         for (int i = 0; i < 4; i++) begin
            #1;
            chk("cnt0_halt", o_halt_n, 1);
            @(negedge i_eclk);
         end
      end else begin
         for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            i_cs_n = 1'b1;
            i_rw   = 1'b1;
            #1;
            if (cyc == 0) chk("start_halt", o_halt_n, 0);
            if (drop_pending) chk("drop_to_req", {o_halt_n, o_bus_oe}, 2'b00);
            drop_pending = 0;
            do_drop = 0;
            if (o_halt_n) begin
               chk("rel_oe", o_bus_oe, 0);
               chk("rel_addr", o_addr, 16'h0000);
               chk("rel_rw", o_rw, 1);
               if (drops == 0) chk("cycles", cyc - first_rd + 1, 2 * cnt + 1);
               fin = 1;
            end else if (!o_bus_oe) begin
               chk("req_addr", o_addr, 16'h0000);
               chk("req_dat_oe", o_data_oe, 0);
               if (wait_n > 0) wait_n--;
               else begin
                  i_ba = 1'b1;
                  i_bs = 1'b1;
               end
               if (busy_io) begin
                  if ($urandom_range(0, 1) == 0) begin
                     i_cs_n = 1'b0;
                     i_rw   = 1'b0;
                     i_addr = {$urandom_range(0, 8191), 3'($urandom_range(0, 6))};
                     i_data = 8'($urandom);
                  end else begin
                     i_cs_n = 1'b0;
                     i_addr = 16'h0006;
                     #1;
                     chk("busy_status", o_data, {1'b1, 1'b0, 4'b0000, ien, 1'b0});
                  end
               end
            end else if (o_rw) begin
               if (first_rd < 0) first_rd = cyc;
               es = src + 16'(k);
               chk("rd_addr", o_addr, es);
               chk("rd_dat_oe", o_data_oe, 0);
               i_data = mem_byte(o_addr);
               if (rnd_drop && drops < 3 && $urandom_range(0, 5) == 0) do_drop = 1;
            end else begin
               es = src + 16'(k);
               ed = dst + 16'(k);
               chk("wr_addr", o_addr, ed);
               chk("wr_dat", o_data, mem_byte(es));
               chk("wr_dat_oe", o_data_oe, 1);
               if (k == drop_at && !drop_done) do_drop = 1;
               else if (rnd_drop && drops < 3 && $urandom_range(0, 5) == 0) do_drop = 1;
               if (!do_drop) k++;
            end
            if (do_drop) begin
               drop_done = 1;
               drops++;
               drop_pending = 1;
               if (drop_at >= 0 || $urandom_range(0, 1) == 0) i_ba = 1'b0;
               else i_bs = 1'b0;
               wait_n = $urandom_range(0, 2);
            end
            @(negedge i_eclk);
         end
         if (!fin) chk("timeout", 0, 1);
         chk("bytes", k, cnt);
      end
      i_ba = 1'b0;
      i_bs = 1'b0;
      i_cs_n = 1'b1;
      i_rw = 1'b1;
      #1;
      chk("irq_done", o_irq_n, !ien);
      reg_rd(16'd6, d);
      chk("status_done", d, {1'b0, 1'b1, 4'b0000, ien, 1'b0});
      #1;
      chk("irq_clr", o_irq_n, 1);
      reg_rd(16'd6, d);
      chk("status_clr", d, {1'b0, 1'b0, 4'b0000, ien, 1'b0});
      es = src + cnt;
      ed = dst + cnt;
      reg_rd(16'd0, d); chk("src_hi", d, es[15:8]);
      reg_rd(16'd1, d); chk("src_lo", d, es[7:0]);
      reg_rd(16'd2, d); chk("dst_hi", d, ed[15:8]);
      reg_rd(16'd3, d); chk("dst_lo", d, ed[7:0]);
      reg_rd(16'd4, d); chk("cnt_hi", d, 0);
      reg_rd(16'd5, d); chk("cnt_lo", d, 0);
      reg_rd(16'd7, d); chk("reg7", d, 0);
   endtask

   task automatic rst_test();
      logic [7:0] d;
      bit         seen;
      reg_wr(16'd0, 8'h12);
      reg_wr(16'd1, 8'h34);
      reg_wr(16'd2, 8'h56);
      reg_wr(16'd3, 8'h78);
      reg_wr(16'd4, 8'h00);
      reg_wr(16'd5, 8'h05);
      reg_wr(16'd6, 8'h03);
      i_ba = 1'b1;
      i_bs = 1'b1;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         #1;
         if (o_bus_oe && o_rw) seen = 1;
         else @(negedge i_eclk);
      end
      chk("rst_reach_rd", seen, 1);
      i_data = 8'h3C;
      #2;
      i_reset = 1'b0;
      #1;
      chk("rst_async_halt", o_halt_n, 1);
      chk("rst_async_oe", o_bus_oe, 0);
      chk("rst_async_addr", o_addr, 16'h0000);
      chk("rst_async_rw", o_rw, 1);
      chk("rst_async_doe", o_data_oe, 0);
      chk("rst_async_irq", o_irq_n, 1);
      repeat (2) begin
         @(negedge i_eclk);
         #1;
         chk("rst_hold_oe", o_bus_oe, 0);
         chk("rst_hold_halt", o_halt_n, 1);
      end
      i_reset = 1'b1;
      i_ba = 1'b0;
      i_bs = 1'b0;
      for (int a = 0; a < 8; a++) begin
         reg_rd(16'(a), d);
         chk("rst_reg", d, 0);
      end
   endtask

   initial begin
      i_reset = 1'b0;
      i_cs_n  = 1'b0;
      i_rw    = 1'b1;
      i_addr  = 16'h0006;
      i_data  = 8'h00;
      i_ba    = 1'b0;
      i_bs    = 1'b0;
      repeat (2) @(negedge i_eclk);
      #1;
      chk("reset_halt", o_halt_n, 1);
      chk("reset_irq", o_irq_n, 1);
      chk("reset_oe", o_bus_oe, 0);
      chk("reset_doe", o_data_oe, 0);
      chk("reset_addr", o_addr, 16'h0000);
      chk("reset_rw", o_rw, 1);
      chk("reset_data", o_data, 8'h00);
      i_cs_n  = 1'b1;
      i_reset = 1'b1;

      run_xfer(16'h1000, 16'h2000, 16'h0003, 8'h03, 2, -1, 0, 0);
      run_xfer(16'h5555, 16'h6666, 16'h0000, 8'h01, 0, -1, 0, 0);
      run_xfer(16'hFFFF, 16'hFFFE, 16'h0003, 8'h01, 1, -1, 0, 0);
      run_xfer(16'h3000, 16'h4000, 16'h0004, 8'h03, 1, 1, 0, 0);
      run_xfer(16'h7000, 16'h8000, 16'h0002, 8'h01, 3, -1, 0, 1);
      rst_test();
      run_xfer(16'h0100, 16'h0200, 16'h0002, 8'h03, 0, -1, 0, 0);

      for (int t = 0; t < 30; t++) begin
         logic [15:0] s;
         logic [15:0] dd;
         logic [15:0] c;
         logic        ie;
         s  = 16'($urandom);
         dd = 16'($urandom);
         if (t % 4 == 0) s = 16'hFFFF - 16'($urandom_range(0, 3));
         if (t % 4 == 1) dd = 16'hFFFF - 16'($urandom_range(0, 3));
         c  = 16'($urandom_range(0, 6));
         ie = 1'($urandom_range(0, 1));
         run_xfer(s, dd, c, {6'b000000, ie, 1'b1}, $urandom_range(0, 3), -1, 1,
                  1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
